// File: rtl/boot_pkg.sv
// Shared definitions for the byte-stream instruction-memory boot loader.
package boot_pkg;

  localparam int unsigned IM_AW         = 14;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_SYNC = 4'd1,
    S_CNT_HI    = 4'd2,
    S_CNT_LO    = 4'd3,
    S_DATA_HI   = 4'd4,
    S_DATA_LO   = 4'd5,
    S_WRITE     = 4'd6,
    S_CSUM      = 4'd7,
    S_DONE      = 4'd8,
    S_ERR       = 4'd9
  } boot_state_e;

  // States in which the inter-byte timeout runs (frame has started).
  function automatic logic in_frame(input boot_state_e s);
    return s inside {S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CSUM};
  endfunction

  // States in which the loader is armed and may consume bytes.
  function automatic logic is_busy(input boot_state_e s);
    return (s == S_WAIT_SYNC) || in_frame(s);
  endfunction

endpackage

// File: rtl/byte_skid.sv
// One-entry byte buffer holding a received byte the FSM could not take yet.
module byte_skid (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_data,
  output logic       o_valid,
  output logic [7:0] o_data
);

  logic       r_vld;
  logic [7:0] r_data;

  // Clear wins, a push replaces a popped entry, a bare pop empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_data <= 8'h00;
    end else if (i_clr) begin
      r_vld  <= 1'b0;
    end else if (i_push) begin
      r_vld  <= 1'b1;
      r_data <= i_data;
    end else if (i_pop) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_valid = r_vld;
  assign o_data  = r_data;

endmodule

// File: rtl/im_boot_loader.sv
// Boot loader: frames a UART byte stream and writes 16-bit words into the IM
// through its debug port; holds the CPU in reset until the checksum matches.
module im_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 16384,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic [15:0] addr,
  output logic        debug,
  inout  wire  [15:0] instr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_rst_n
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  boot_state_e r_state, w_state_nxt;

  logic [15:0]      r_cnt;
  logic [IM_AW-1:0] r_addr;
  logic [15:0]      r_word;
  logic [7:0]       r_sum;
  logic [TMO_W-1:0] r_tmo;
  logic             r_debug, r_busy, r_done, r_err, r_cpu_rst_n;

  logic       w_skid_vld;
  logic [7:0] w_skid_data;
  logic       w_b0_vld, w_b1_vld;
  logic [7:0] w_b0, w_b1;
  logic       w_take0, w_take1;
  logic       w_rx_taken, w_push, w_pop, w_clr;
  logic [15:0] w_n;
  logic       w_tmo_hit;

  // Oldest byte comes from the skid slot; a live byte behind it is the second.
  assign w_b0_vld = w_skid_vld | rx_rdy;
  assign w_b0     = w_skid_vld ? w_skid_data : rx_data;
  assign w_b1_vld = w_skid_vld & rx_rdy;
  assign w_b1     = rx_data;
  assign w_n      = {r_cnt[15:8], w_b0};
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYC));

  assign w_rx_taken = (w_take0 & ~w_skid_vld) | w_take1;
  assign w_push     = rx_rdy & ~w_rx_taken;
  assign w_pop      = w_take0 & w_skid_vld;
  assign w_clr      = ~is_busy(w_state_nxt);

  byte_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (rx_data),
    .o_valid (w_skid_vld),
    .o_data  (w_skid_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and byte-consume strobes. DATA_HI may take two bytes at once
  // (skid + live) so back-to-back bytes keep pace with the WRITE bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_take0     = 1'b0;
    w_take1     = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_state_nxt = S_WAIT_SYNC;
      end
      S_WAIT_SYNC: begin
        if (w_b0_vld) begin
          w_take0 = 1'b1;
          if (w_b0 == SYNC_BYTE) w_state_nxt = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (w_b0_vld) begin
          w_take0     = 1'b1;
          w_state_nxt = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (w_b0_vld) begin
          w_take0 = 1'b1;
          if (w_n == 16'd0)                 w_state_nxt = S_CSUM;
          else if (32'(w_n) > MEM_DEPTH)    w_state_nxt = S_ERR;
          else                              w_state_nxt = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (w_b0_vld) begin
          w_take0 = 1'b1;
          if (w_b1_vld) begin
            w_take1     = 1'b1;
            w_state_nxt = S_WRITE;
          end else begin
            w_state_nxt = S_DATA_LO;
          end
        end
      end
      S_DATA_LO: begin
        if (w_b0_vld) begin
          w_take0     = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        w_state_nxt = (r_cnt == 16'd1) ? S_CSUM : S_DATA_HI;
      end
      S_CSUM: begin
        if (w_b0_vld) begin
          w_take0     = 1'b1;
          w_state_nxt = (w_b0 == r_sum) ? S_DONE : S_ERR;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (in_frame(r_state) && w_tmo_hit) begin
      w_state_nxt = S_ERR;
      w_take0     = 1'b0;
      w_take1     = 1'b0;
    end
  end

  // Count, address, word assembly and running checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 16'h0000;
      r_addr <= '0;
      r_word <= 16'h0000;
      r_sum  <= 8'h00;
    end else begin
      if (r_state == S_WAIT_SYNC) begin
        r_sum <= 8'h00;
      end else if (w_take0 && (r_state inside {S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO})) begin
        r_sum <= r_sum + w_b0 + (w_take1 ? w_b1 : 8'h00);
      end
      case (r_state)
        S_CNT_HI:  if (w_take0) r_cnt[15:8] <= w_b0;
        S_CNT_LO:  if (w_take0) begin
                     r_cnt[7:0] <= w_b0;
                     r_addr     <= '0;
                   end
        S_DATA_HI: begin
                     if (w_take0) r_word[15:8] <= w_b0;
                     if (w_take1) r_word[7:0]  <= w_b1;
                   end
        S_DATA_LO: if (w_take0) r_word[7:0] <= w_b0;
        S_WRITE:   begin
                     r_addr <= r_addr + IM_AW'(1);
                     r_cnt  <= r_cnt - 16'd1;
                   end
        default:   ;
      endcase
    end
  end

  // Inter-byte timeout: cleared by every received byte, runs only in-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_tmo <= '0;
    else if (!in_frame(r_state) || rx_rdy) r_tmo <= '0;
    else if (!w_tmo_hit)                r_tmo <= r_tmo + TMO_W'(1);
  end

  // Registered status outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_debug     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      r_debug     <= (w_state_nxt == S_WRITE);
      r_busy      <= is_busy(w_state_nxt);
      r_done      <= (w_state_nxt == S_DONE);
      r_err       <= (w_state_nxt == S_ERR);
      r_cpu_rst_n <= (w_state_nxt == S_DONE);
    end
  end

  assign addr      = {2'b00, r_addr};
  assign debug     = r_debug;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign cpu_rst_n = r_cpu_rst_n;

  // Drive the IM bus only during the write cycle; the IM releases it then.
  assign instr = r_debug ? r_word : 16'hzzzz;

endmodule
